// File: rtl/dsc_s2b3.sv
// dsc_s2b3 -- three-channel stochastic bitstream decoder.
// Counts the ones on three bitstreams over a window of 2^SNG_WIDTH cycles.
// It then presents the three counts through a valid/ready handshake.
// Optional feature: define DSC_S2B3_SORT_OUT_EN to add one SORT cycle.
// With that macro the counts are presented in descending order.
module dsc_s2b3 #(
  parameter int SNG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           bit_in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [SNG_WIDTH:0]   a_new,
  output logic [SNG_WIDTH:0]   b_new,
  output logic [SNG_WIDTH:0]   c_new
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
`ifdef DSC_S2B3_SORT_OUT_EN
    SORT  = 2'd2,
`endif
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [SNG_WIDTH:0]   acc_a;
  logic [SNG_WIDTH:0]   acc_b;
  logic [SNG_WIDTH:0]   acc_c;
  logic [SNG_WIDTH-1:0] cnt;

  logic [SNG_WIDTH:0]   sum_a;
  logic [SNG_WIDTH:0]   sum_b;
  logic [SNG_WIDTH:0]   sum_c;
  logic                 last_sample;

  // The sums include the current sample, so the final counts can be
  // loaded on the same edge that takes the last sample.
  assign sum_a = acc_a + (SNG_WIDTH+1)'(bit_in[0]);
  assign sum_b = acc_b + (SNG_WIDTH+1)'(bit_in[1]);
  assign sum_c = acc_c + (SNG_WIDTH+1)'(bit_in[2]);

  // The counter reaching all-ones marks the final sample of the window.
  // Its wrap back to 0 therefore never adds an extra cycle.
  assign last_sample = (state == ACCUM) && (cnt == {SNG_WIDTH{1'b1}});

  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

`ifdef DSC_S2B3_SORT_OUT_EN
  logic [SNG_WIDTH:0] max1, min1, max2, min2, srt_hi, srt_mid;

  // This is a three-stage compare-and-swap network.
  // A pair is swapped only when the first operand is strictly smaller,
  // so ties keep their input order.
  always_comb begin
    max1 = acc_a;
    min1 = acc_b;
    if (acc_a < acc_b) begin
      max1 = acc_b;
      min1 = acc_a;
    end
    max2 = min1;
    min2 = acc_c;
    if (min1 < acc_c) begin
      max2 = acc_c;
      min2 = min1;
    end
    srt_hi  = max1;
    srt_mid = max2;
    if (max1 < max2) begin
      srt_hi  = max2;
      srt_mid = max1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  // start is looked at only in IDLE, and out_ready only in HOLD.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = ACCUM;
      ACCUM: if (last_sample) begin
`ifdef DSC_S2B3_SORT_OUT_EN
               next_state = SORT;
`else
               next_state = HOLD;
`endif
             end
`ifdef DSC_S2B3_SORT_OUT_EN
      SORT:  next_state = HOLD;
`endif
      HOLD:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accumulators, window counter and result registers.
  // The results keep their last delivered value until the next window
  // overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a <= '0;
      acc_b <= '0;
      acc_c <= '0;
      cnt   <= '0;
      a_new <= '0;
      b_new <= '0;
      c_new <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_a <= '0;
            acc_b <= '0;
            acc_c <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          acc_a <= sum_a;
          acc_b <= sum_b;
          acc_c <= sum_c;
          cnt   <= cnt + SNG_WIDTH'(1);
`ifndef DSC_S2B3_SORT_OUT_EN
          if (last_sample) begin
            a_new <= sum_a;
            b_new <= sum_b;
            c_new <= sum_c;
          end
`endif
        end
`ifdef DSC_S2B3_SORT_OUT_EN
        SORT: begin
          a_new <= srt_hi;
          b_new <= srt_mid;
          c_new <= min2;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_s2b3.sv
// Self-checking bench for dsc_s2b3: it runs randomized bitstream windows
// against a counting/sorting reference model.
module tb_dsc_s2b3;

  localparam int N = 64;
`ifdef DSC_S2B3_SORT_OUT_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] bit_in = '0;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [6:0] a_new;
  logic [6:0] b_new;
  logic [6:0] c_new;

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  int last_a = 0;
  int last_b = 0;
  int last_c = 0;

  dsc_s2b3 #(.SNG_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
    .a_new(a_new), .b_new(b_new), .c_new(c_new)
  );

  always #5 clk = ~clk;

  // Count completed handshakes.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_count++;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Build a stream with exactly 'ones' set bits at random positions.
  function automatic logic [N-1:0] makeStream(input int ones);
    logic [N-1:0] s;
    logic t;
    int j;
    s = '0;
    for (int i = 0; i < ones; i++) s[i] = 1'b1;
    for (int i = N-1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    return s;
  endfunction

  // Reference model: the count of ones per channel, optionally sorted descending.
  task automatic refModel(input logic [N-1:0] sa, input logic [N-1:0] sb,
                          input logic [N-1:0] sc, output int ea, output int eb,
                          output int ec);
    int v[3];
    v[0] = $countones(sa);
    v[1] = $countones(sb);
    v[2] = $countones(sc);
`ifdef DSC_S2B3_SORT_OUT_EN
    for (int p = 0; p < 2; p++)
      for (int q = 0; q < 2 - p; q++)
        if (v[q] < v[q+1]) begin
          int t;
          t = v[q]; v[q] = v[q+1]; v[q+1] = t;
        end
`endif
    ea = v[0];
    eb = v[1];
    ec = v[2];
  endtask

  // One full window: start, N samples, result, optional back-pressure, handshake.
  task automatic applyStimulus(input logic [N-1:0] sa, input logic [N-1:0] sb,
                               input logic [N-1:0] sc, input int ready_delay,
                               input int s1, input int s2, input bit hs_start,
                               input string tag);
    int ea, eb, ec, lat, hs_before;
    refModel(sa, sb, sc, ea, eb, ec);
    hs_before = hs_count;
    out_ready = (ready_delay == 0);
    @(negedge clk);
    start = 1'b1;
    bit_in = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_accum"}, int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      bit_in = {sc[i], sb[i], sa[i]};
      start = (i == s1) || (i == s2);
      if (i == 5) begin
        checkOutput({tag, "_retain_a"}, int'(a_new), last_a);
        checkOutput({tag, "_retain_c"}, int'(c_new), last_c);
        checkOutput({tag, "_valid_accum"}, int'(out_valid), 0);
      end
      @(negedge clk);
    end
    bit_in = '0;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, EXP_LAT);
    checkOutput({tag, "_a"}, int'(a_new), ea);
    checkOutput({tag, "_b"}, int'(b_new), eb);
    checkOutput({tag, "_c"}, int'(c_new), ec);
    checkOutput({tag, "_no_x"}, int'($isunknown({a_new, b_new, c_new, out_valid, busy})), 0);
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
      checkOutput({tag, "_hold_a"}, int'(a_new), ea);
      checkOutput({tag, "_hold_b"}, int'(b_new), eb);
      checkOutput({tag, "_hold_c"}, int'(c_new), ec);
    end
    out_ready = 1'b1;
    start = hs_start;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_after"}, int'(out_valid), 0);
    checkOutput({tag, "_busy_after"}, int'(busy), 0);
    checkOutput({tag, "_handshakes"}, hs_count - hs_before, 1);
    checkOutput({tag, "_idle_b"}, int'(b_new), eb);
    last_a = ea;
    last_b = eb;
    last_c = ec;
  endtask

  logic [N-1:0] alt;
  int seen_valid;

  initial begin
    // Power-on reset.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_a", int'(a_new), 0);
    checkOutput("rst_b", int'(b_new), 0);
    checkOutput("rst_c", int'(c_new), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full stream, empty stream, and an alternating stream.
    for (int i = 0; i < N; i++) alt[i] = (i % 2 == 0);
    applyStimulus({N{1'b1}}, '0, alt, 0, -1, -1, 1'b0, "full_zero_alt");

    // Distinct densities.
    applyStimulus(makeStream(10), makeStream(40), makeStream(20), 0, -1, -1, 1'b0, "dens_10_40_20");

    // Back-pressure for 5 cycles.
    applyStimulus(makeStream($urandom_range(64, 0)), makeStream($urandom_range(64, 0)),
                  makeStream($urandom_range(64, 0)), 5, -1, -1, 1'b0, "backpressure");

    // Spurious starts during ACCUM and at the handshake.
    applyStimulus(makeStream(33), makeStream(7), makeStream(50), 0, 3, 40, 1'b1, "spurious_start");
    @(negedge clk);
    checkOutput("spurious_idle", int'(busy), 0);

    // Reset in the middle of a window.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bit_in = 3'b111;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_a", int'(a_new), 0);
    checkOutput("midrst_c", int'(c_new), 0);
    last_a = 0;
    last_b = 0;
    last_c = 0;
    bit_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    checkOutput("midrst_no_valid", seen_valid, 0);
    applyStimulus(makeStream(25), makeStream(60), makeStream(3), 1, -1, -1, 1'b0, "after_reset");

    // Equal densities.
    applyStimulus(makeStream(16), makeStream(16), makeStream(16), 0, -1, -1, 1'b0, "equal_16");

    // Random windows.
    for (int r = 0; r < 6; r++) begin
      applyStimulus(makeStream($urandom_range(64, 0)), makeStream($urandom_range(64, 0)),
                    makeStream($urandom_range(64, 0)), $urandom_range(3, 0), -1, -1,
                    1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
